// File: rtl/xalu_ctrl.sv
// +--------------------------------------------------------------------------+
// | xalu_ctrl : E-stage mult/div sequencer, HI/LO owner, F/D stall request   |
// | Optional feature macro: XALU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate)  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module xalu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        out_sel,
  input  logic        d_uses_xalu,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] XALUOUT
);

  localparam logic [3:0] c_OP_MULT  = 4'd0;
  localparam logic [3:0] c_OP_MULTU = 4'd1;
  localparam logic [3:0] c_OP_DIV   = 4'd2;
  localparam logic [3:0] c_OP_DIVU  = 4'd3;
  localparam logic [3:0] c_OP_MTHI  = 4'd4;
  localparam logic [3:0] c_OP_MTLO  = 4'd5;
  localparam logic [3:0] c_OP_MADD  = 4'd6;
  localparam logic [3:0] c_OP_MADDU = 4'd7;
  localparam logic [3:0] c_OP_MSUB  = 4'd8;
  localparam logic [3:0] c_OP_MSUBU = 4'd9;

  localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        w_is_multi;
  logic        w_start_is_div;
  logic        w_sgn;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a, w_abs_b, w_den, w_q_mag, w_r_mag, w_quot, w_rem;
  logic [63:0] w_result;

  always_comb begin
    w_is_multi = 1'b0;
    case (op)
      c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: w_is_multi = 1'b1;
`ifdef XALU_MADD_EN
      c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: w_is_multi = 1'b1;
`endif
      default: w_is_multi = 1'b0;
    endcase
  end

  assign w_start_is_div = (op == c_OP_DIV) || (op == c_OP_DIVU);

  // One shared multiplier and one unsigned divider serve signed and unsigned forms.
  assign w_sgn   = (op_q == c_OP_MULT) || (op_q == c_OP_DIV) ||
                   (op_q == c_OP_MADD) || (op_q == c_OP_MSUB);
  assign w_prod  = {{32{w_sgn & a_q[31]}}, a_q} * {{32{w_sgn & b_q[31]}}, b_q};
  assign w_abs_a = (w_sgn && a_q[31]) ? -a_q : a_q;
  assign w_abs_b = (w_sgn && b_q[31]) ? -b_q : b_q;
  assign w_den   = (b_q == 32'd0) ? 32'd1 : w_abs_b;
  assign w_q_mag = w_abs_a / w_den;
  assign w_r_mag = w_abs_a % w_den;
  assign w_quot  = (w_sgn && (a_q[31] ^ b_q[31])) ? -w_q_mag : w_q_mag;
  assign w_rem   = (w_sgn && a_q[31]) ? -w_r_mag : w_r_mag;

  always_comb begin
    w_result = {hi_q, lo_q};
    case (op_q)
      c_OP_MULT, c_OP_MULTU: w_result = w_prod;
      c_OP_DIV, c_OP_DIVU:
        w_result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {w_rem, w_quot};
`ifdef XALU_MADD_EN
      c_OP_MADD, c_OP_MADDU: w_result = {hi_q, lo_q} + w_prod;
      c_OP_MSUB, c_OP_MSUBU: w_result = {hi_q, lo_q} - w_prod;
`endif
      default: w_result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (w_is_multi) begin
            state_d = S_BUSY;
            count_d = w_start_is_div ? c_DIV_CNT : c_MULT_CNT;
            op_d    = op;
            a_d     = A;
            b_d     = B;
          end else if (op == c_OP_MTHI) begin
            hi_d = A;
          end else if (op == c_OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_BUSY: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d    = S_IDLE;
          {hi_d, lo_d} = w_result;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  // Asserted in the start cycle too, so the trailing D-stage op cannot slip past.
  assign stall_req = d_uses_xalu & (busy | (start & w_is_multi));
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign XALUOUT   = out_sel ? hi_q : lo_q;

endmodule

`default_nettype wire

// File: tb/tb_xalu_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_xalu_ctrl : self-checking bench for xalu_ctrl                         |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_xalu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, out_sel, d_uses_xalu;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, stall_req;
  logic [31:0] HI, LO, XALUOUT;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  xalu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .out_sel(out_sel), .d_uses_xalu(d_uses_xalu), .busy(busy),
    .stall_req(stall_req), .HI(HI), .LO(LO), .XALUOUT(XALUOUT)
  );

  always #5 clk = ~clk;

  function automatic bit is_multi(input logic [3:0] o);
`ifdef XALU_MADD_EN
    return o <= 4'd9 && o != 4'd4 && o != 4'd5;
`else
    return o <= 4'd3;
`endif
  endfunction

  // Reference arithmetic straight from the instruction definitions, in 64-bit integers.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      4'd0: return sa * sb;
      4'd1: return ua * ub;
      4'd2: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      4'd3: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(ua % ub), 32'(ua / ub)};
`ifdef XALU_MADD_EN
      4'd6: return acc + 64'(sa * sb);
      4'd7: return acc + 64'(ua * ub);
      4'd8: return acc - 64'(sa * sb);
      4'd9: return acc - 64'(ua * ub);
`endif
      default: return acc;
    endcase
  endfunction

  // Model: an accepted op owns the unit until its commit edge, N edges after acceptance.
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [3:0]  m_op = 0;
  bit          m_pend = 0;
  longint      m_cyc = 0, m_commit = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi   <= 0;
      m_lo   <= 0;
      m_pend <= 0;
    end else if (m_pend) begin
      if (m_cyc == m_commit) begin
        {m_hi, m_lo} <= ref_result(m_op, m_a, m_b, {m_hi, m_lo});
        m_pend <= 0;
      end
    end else if (start) begin
      if (is_multi(op)) begin
        m_pend   <= 1;
        m_op     <= op;
        m_a      <= A;
        m_b      <= B;
        m_commit <= m_cyc + ((op == 4'd2 || op == 4'd3) ? DC : MC);
      end else if (op == 4'd4) begin
        m_hi <= A;
      end else if (op == 4'd5) begin
        m_lo <= A;
      end
    end
    m_cyc <= m_cyc + 1;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(m_pend));
      cmp("stall_req", 32'(stall_req),
          32'(d_uses_xalu & (m_pend | (start & is_multi(op)))));
      cmp("HI", HI, m_hi);
      cmp("LO", LO, m_lo);
      cmp("XALUOUT", XALUOUT, out_sel ? m_hi : m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    op    = 4'hF;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy=%b expected 0 within 40 cycles", busy);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; A = 0; B = 0;
    out_sel = 1'b0; d_uses_xalu = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_HI", HI, 32'd0);
    cmp("rst_LO", LO, 32'd0);

    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    cmp("mult_HI", HI, 32'hFFFF_FFFF);
    cmp("mult_LO", LO, 32'hFFFF_FFFA);

    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    cmp("multu_HI", HI, 32'hFFFF_FFFE);
    cmp("multu_LO", LO, 32'h0000_0001);

    out_sel = 1'b1;
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    cmp("div_LO", LO, 32'hFFFF_FFFD);
    cmp("div_HI", HI, 32'hFFFF_FFFF);

    issue(4'd3, 32'd7, 32'd0);
    wait_idle();
    cmp("divu0_LO", LO, 32'hFFFF_FFFF);
    cmp("divu0_HI", HI, 32'd7);

    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    cmp("divovf_LO", LO, 32'h8000_0000);
    cmp("divovf_HI", HI, 32'd0);

    issue(4'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle();
    issue(4'd3, 32'd100, 32'd7);
    wait_idle();
    cmp("divu_LO", LO, 32'd14);
    cmp("divu_HI", HI, 32'd2);

    d_uses_xalu = 1'b1;
    issue(4'd0, 32'd1000, 32'd1000);
    cmp("stall_busy", 32'(stall_req), 32'd1);
    tick();
    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    cmp("stall_after", 32'(stall_req), 32'd0);
    cmp("ignored_HI", HI, 32'd0);
    cmp("ignored_LO", LO, 32'h000F_4240);
    tick();
    d_uses_xalu = 1'b0;

    out_sel = 1'b0;
    issue(4'd5, 32'h0000_1234, 32'd0);
    cmp("mtlo_LO", LO, 32'h0000_1234);
    cmp("mtlo_busy", 32'(busy), 32'd0);
    cmp("mtlo_XALUOUT", XALUOUT, 32'h0000_1234);
    issue(4'd4, 32'hCAFE_0001, 32'd0);
    out_sel = 1'b1;
    tick();
    cmp("mthi_XALUOUT", XALUOUT, 32'hCAFE_0001);

    issue(4'd12, 32'd5, 32'd5);
    cmp("undef_busy", 32'(busy), 32'd0);
`ifndef XALU_MADD_EN
    issue(4'd6, 32'd5, 32'd5);
    cmp("madd_off_busy", 32'(busy), 32'd0);
`endif
    tick();

`ifdef XALU_MADD_EN
    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'd5, 32'd0);
    issue(4'd6, 32'd2, 32'd3);
    wait_idle();
    cmp("madd_LO", LO, 32'd11);
    cmp("madd_HI", HI, 32'd0);
    issue(4'd8, 32'd4, 32'd4);
    wait_idle();
    cmp("msub_LO", LO, 32'hFFFF_FFFB);
    cmp("msub_HI", HI, 32'hFFFF_FFFF);
`endif

    issue(4'd2, 32'd100, 32'd3);
    tick();
    tick();
    cmp("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("abort_busy", 32'(busy), 32'd0);
    cmp("abort_HI", HI, 32'd0);
    cmp("abort_LO", LO, 32'd0);
    repeat (12) tick();
    cmp("abort_nocommit_LO", LO, 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
